spike_event_encoder: RTL
========================

Name: spike_event_encoder

Overview:
- Consumer of the neuron core's membrane-potential stream: samples V once per integration step, detects action potentials by threshold crossing with hysteresis, and enforces a refractory window.
- For each spike it emits a one-cycle pulse plus an event word carrying the inter-spike interval (ISI). The event word uses a valid/ready handshake toward downstream logic (output mux or serializer).
- Also keeps a running spike count.

Parameters:
- REFRACT_SAMPLES, 8, number of accepted samples spent in REFRACT before re-arming (1..255).
- ISI_W, 16, width of the ISI counter and event field.
- CNT_W, 8, width of the spike counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- v_in  in  16  membrane potential, signed Q8.8 mV
- v_valid  in  1  v_in is a new sample this cycle (one per dt step)
- thresh_hi  in  16  signed Q8.8 spike threshold
- thresh_lo  in  16  signed Q8.8 re-arm threshold
- clear  in  1  clears overrun flag and spike_count
- spike  out  1  one-cycle pulse per detected spike
- event_isi  out  ISI_W  ISI in samples for the pending event
- event_valid  out  1  event_isi holds an unconsumed event
- event_ready  in  1  downstream accepts the event
- spike_count  out  CNT_W  total spikes, wraps modulo 2^CNT_W
- overrun  out  1  sticky: a spike event was dropped

Behaviour:
- Reset (reset==0 at a clock edge): state=BELOW, spike=0, event_valid=0, event_isi=0, spike_count=0, overrun=0, refractory counter=0, ISI counter=all-ones, first_flag=1.
- All comparisons are signed 16-bit: spike when v_in >= thresh_hi; re-arm when v_in < thresh_lo.
- Only edges with v_valid=1 advance the FSM, the ISI counter or the refractory counter.
- ISI counter: +1 per accepted sample, saturating at 2^ISI_W-1.
- FSM:
  - BELOW, v_in >= thresh_hi -> ABOVE. This is the spike event.
  - ABOVE, v_in < thresh_lo -> REFRACT; load refractory counter with REFRACT_SAMPLES.
  - ABOVE otherwise: stay, no further events.
  - REFRACT: decrement per accepted sample. On the sample where the counter reaches 0 -> BELOW. Threshold ignored in REFRACT.
  - A sample meeting both conditions in BELOW takes the spike path only.
  - If thresh_lo > thresh_hi, the rules above still apply literally.
- Spike event, registered, one cycle after the accepted sample:
  - spike=1 for exactly one cycle.
  - spike_count +1.
  - ISI counter resets to 0 on the spike sample itself, so the next ISI counts samples after it.
  - Reported ISI = counter value before reset. If first_flag=1, report all-ones instead; first_flag clears at the first spike.
- Handshake:
  - event_valid/event_isi are held stable until event_valid && event_ready at an edge, which then clears event_valid.
  - New spike with event_valid=0, or with event_valid=1 and event_ready=1 the same cycle: load the new event, event_valid stays/becomes 1.
  - New spike with event_valid=1 and event_ready=0: event dropped, pending event untouched, overrun=1. spike and spike_count still update.
- clear: overrun=0 and spike_count=0 next cycle. A coincident spike takes priority and sets spike_count=1 and overrun as per the drop rule.
- Reset mid-operation: everything returns to reset values at that edge and any pending event is lost.
- Latency: accepted sample -> spike/event_valid 1 cycle.

Decomposition:
- Shared package neuron_pkg: Q8.8 format constants (FRAC_BITS=8), default thresholds TH_HI_DEF=0xEC00 (-20 mV) and TH_LO_DEF=0xCE00 (-50 mV), and an FSM state enum {BELOW, ABOVE, REFRACT}.
- One natural sub-module, isi_counter: saturating counter with sync clear and enable.
- FSM, handshake register and flags stay in the top module.

Test Plan:
- Reset, then samples -65 mV (0xBF00) x10 with thresh_hi=0xEC00, thresh_lo=0xCE00 -> no spike, event_valid=0, spike_count=0.
- First spike: ramp to 0x1400 (+20 mV) -> spike pulse 1 cycle after that sample, event_isi=0xFFFF, spike_count=1. Hold event_ready=1 -> event_valid drops next cycle.
- Refractory, REFRACT_SAMPLES=8: after falling below -50 mV, a sample of +20 mV on refractory samples 1..7 -> no spike. On sample 8 the FSM goes to BELOW; the next +20 mV sample -> spike.
- ISI value: spikes exactly 40 samples apart with event_ready=1 -> second event_isi=39 (samples strictly between the two spikes).
- Overrun: event_ready=0 across two spikes -> first event held unchanged, overrun=1, spike_count=2. clear -> overrun=0, spike_count=0.
- Simultaneous events and mid-run reset: spike coincident with event_ready=1 -> new event loaded, overrun stays 0. Drive reset=0 while in ABOVE -> state BELOW and all outputs zero next edge.

Source files
------------

// File: rtl/neuron_pkg.sv
// neuron_pkg: shared Q8.8 membrane-potential constants and spike FSM states
package neuron_pkg;
  localparam int FRAC_BITS = 8;
  localparam logic [15:0] TH_HI_DEF = 16'hEC00;
  localparam logic [15:0] TH_LO_DEF = 16'hCE00;
  typedef enum logic [1:0] {BELOW, ABOVE, REFRACT} state_e;
endpackage

// File: rtl/spike_event_encoder_if.sv
// spike_event_encoder_if: valid/ready event channel carrying the inter-spike interval
interface spike_event_encoder_if #(parameter int ISI_W = 16);
  logic [ISI_W-1:0] event_isi;
  logic event_valid;
  logic event_ready;
  modport master (output event_isi, event_valid, input event_ready);
  modport slave (input event_isi, event_valid, output event_ready);
endinterface

// File: rtl/isi_counter.sv
// isi_counter: saturating sample counter with synchronous clear and enable
module isi_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '1;
    else if (en_i) cnt_q <= clr_i ? '0 : (&cnt_q ? cnt_q : cnt_q + W'(1));
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/spike_event_encoder.sv
// spike_event_encoder: threshold/hysteresis spike detector with refractory window,
// ISI event channel, spike counter and sticky overrun flag
module spike_event_encoder
  import neuron_pkg::*;
#(
  parameter int REFRACT_SAMPLES = 8,
  parameter int ISI_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic signed [15:0]  v_in_i,
  input  logic                v_valid_i,
  input  logic signed [15:0]  thresh_hi_i,
  input  logic signed [15:0]  thresh_lo_i,
  input  logic                clear_i,
  output logic                spike_o,
  output logic [CNT_W-1:0]    spike_count_o,
  output logic                overrun_o,
  spike_event_encoder_if.master evt
);
  state_e state_q, state_d;
  logic [7:0] ref_q, ref_d;
  logic first_q, spike_q, evt_valid_q, ov_q;
  logic [ISI_W-1:0] evt_isi_q, isi;
  logic [CNT_W-1:0] cnt_q;
  logic spike_ev, drop;
  assign spike_ev = v_valid_i && state_q == BELOW && v_in_i >= thresh_hi_i;
  assign drop = spike_ev && evt_valid_q && !evt.event_ready;
  isi_counter #(.W(ISI_W)) u_isi (
    .clk_i(clock_i), .rst_ni(reset_ni), .en_i(v_valid_i), .clr_i(spike_ev), .cnt_o(isi)
  );
  always_comb begin
    state_d = state_q;
    ref_d = ref_q;
    if (spike_ev) state_d = ABOVE;
    else if (v_valid_i && state_q == ABOVE && v_in_i < thresh_lo_i) begin
      state_d = REFRACT;
      ref_d = 8'(REFRACT_SAMPLES);
    end else if (v_valid_i && state_q == REFRACT) begin
      ref_d = ref_q - 8'd1;
      state_d = ref_q <= 8'd1 ? BELOW : REFRACT;
    end
  end
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q <= BELOW;
      ref_q <= '0;
      first_q <= 1'b1;
      spike_q <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_isi_q <= '0;
      cnt_q <= '0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q <= ref_d;
      first_q <= first_q && !spike_ev;
      spike_q <= spike_ev;
      // a dropped spike leaves the pending event untouched but still counts
      evt_valid_q <= (spike_ev && !drop) || (evt_valid_q && !evt.event_ready);
      evt_isi_q <= (spike_ev && !drop) ? (first_q ? '1 : isi) : evt_isi_q;
      cnt_q <= spike_ev ? (clear_i ? CNT_W'(1) : cnt_q + CNT_W'(1)) : (clear_i ? '0 : cnt_q);
      ov_q <= drop || (ov_q && !clear_i);
    end
  end
  assign spike_o = spike_q;
  assign spike_count_o = cnt_q;
  assign overrun_o = ov_q;
  assign evt.event_valid = evt_valid_q;
  assign evt.event_isi = evt_isi_q;
endmodule
